vend_sequencer: RTL and testbench

Transaction controller for the coin-operated vending datapath. Accumulates credit from single-cycle coin pulses (nickel/dime/quarter), and on a valid selection runs a handshake with the product-dispense mechanism. It then returns any change one nickel at a time through the change-dispenser handshake. It sits between the coin acceptor / front panel and the dispense and change actuators, and replaces ad-hoc open/credit FSMs with a single sequenced transaction.

---
 rtl/vend_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_vend_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin-credit accumulator and vend/change transaction sequencer.
// Credit is built from coin pulses. A valid selection runs the dispense
// handshake, and any remaining credit is then paid out one nickel at a time.
module vend_sequencer #(
    parameter int unsigned PRICE      = 15,
    parameter int unsigned MAX_CREDIT = 100,
    parameter int unsigned CREDIT_W   = 8,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                N,
    input  logic                D,
    input  logic                Q,
    input  logic                Sel,
    input  logic                Cancel,
    input  logic                DispDone,
    input  logic                ChgAck,
    output logic                DispReq,
    output logic                ChgReq,
    output logic                CoinRej,
    output logic                Busy,
    output logic [CREDIT_W-1:0] Credit
);

    // Timer counts idle CREDIT cycles 0..TIMEOUT-1
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CREDIT = 2'd1;
    localparam logic [1:0] ST_VEND   = 2'd2;
    localparam logic [1:0] ST_CHANGE = 2'd3;

    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] MAX_C     = CREDIT_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] DIME_C    = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(25);
    localparam logic [TMR_W-1:0]    TMR_LAST  = TMR_W'(TIMEOUT - 1);

    logic [1:0]          state;
    logic [1:0]          state_n;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] credit_n;
    logic [TMR_W-1:0]    timer;
    logic [TMR_W-1:0]    timer_n;

    logic [CREDIT_W-1:0] coin_val;
    logic                coin_any;
    logic                coin_multi;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic                coin_ok;
    logic                sel_ok;

    logic                disp_req_n;
    logic                chg_req_n;
    logic                coin_rej_n;
    logic                busy_n;

    // Coin decode: quarter beats dime beats nickel; the losers are always returned
    always_comb begin
        coin_val   = '0;
        coin_any   = N | D | Q;
        coin_multi = (N & D) | (N & Q) | (D & Q);
        if (Q) begin
            coin_val = QUARTER_C;
        end else if (D) begin
            coin_val = DIME_C;
        end else if (N) begin
            coin_val = NICKEL_C;
        end
        coin_sum  = {1'b0, credit} + {1'b0, coin_val};
        coin_fits = (coin_sum <= {1'b0, MAX_C});
        sel_ok    = Sel && (credit >= PRICE_C);
    end

    // Next-state, credit and idle-timer update
    always_comb begin
        state_n  = state;
        credit_n = credit;
        timer_n  = timer;
        coin_ok  = 1'b0;

        case (state)
            ST_IDLE: begin
                timer_n = '0;
                if (coin_any && coin_fits) begin
                    coin_ok  = 1'b1;
                    credit_n = coin_sum[CREDIT_W-1:0];
                    state_n  = ST_CREDIT;
                end
            end

            ST_CREDIT: begin
                if (Cancel) begin
                    timer_n = '0;
                    state_n = ST_CHANGE;
                end else if (sel_ok) begin
                    timer_n  = '0;
                    credit_n = credit - PRICE_C;
                    state_n  = ST_VEND;
                end else if (coin_any && coin_fits) begin
                    coin_ok  = 1'b1;
                    timer_n  = '0;
                    credit_n = coin_sum[CREDIT_W-1:0];
                end else if (timer == TMR_LAST) begin
                    // Customer walked away: refund whatever is held
                    timer_n = '0;
                    state_n = ST_CHANGE;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end

            ST_VEND: begin
                if (DispDone) begin
                    state_n = (credit != '0) ? ST_CHANGE : ST_IDLE;
                end
            end

            ST_CHANGE: begin
                if (credit == '0) begin
                    // Nothing owed; cannot normally occur but never strand the FSM
                    state_n = ST_IDLE;
                end else if (ChgAck) begin
                    credit_n = credit - NICKEL_C;
                    if (credit == NICKEL_C) begin
                        state_n = ST_IDLE;
                    end
                end
            end

            default: begin
                state_n  = ST_IDLE;
                credit_n = '0;
                timer_n  = '0;
            end
        endcase
    end

    // Output values for the next cycle, derived from the state being entered
    always_comb begin
        disp_req_n = (state_n == ST_VEND);
        chg_req_n  = (state_n == ST_CHANGE);
        busy_n     = (state_n == ST_VEND) || (state_n == ST_CHANGE);
        coin_rej_n = coin_multi || (coin_any && !coin_ok);
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= ST_IDLE;
            credit <= '0;
            timer  <= '0;
        end else begin
            state  <= state_n;
            credit <= credit_n;
            timer  <= timer_n;
        end
    end

    // Registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            DispReq <= 1'b0;
            ChgReq  <= 1'b0;
            CoinRej <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            DispReq <= disp_req_n;
            ChgReq  <= chg_req_n;
            CoinRej <= coin_rej_n;
            Busy    <= busy_n;
        end
    end

    assign Credit = credit;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: each step pushes the expected outputs,
// applies one cycle of stimulus and pops the expectation to compare.
module tb_vend_sequencer;

    localparam int unsigned CW = 8;
    localparam int unsigned TO = 8;

    // Stimulus vector bits: {Reset, N, D, Q, Sel, Cancel, DispDone, ChgAck}
    localparam logic [7:0] I_NONE = 8'h00;
    localparam logic [7:0] I_RST  = 8'h80;
    localparam logic [7:0] I_N    = 8'h40;
    localparam logic [7:0] I_D    = 8'h20;
    localparam logic [7:0] I_Q    = 8'h10;
    localparam logic [7:0] I_SEL  = 8'h08;
    localparam logic [7:0] I_CAN  = 8'h04;
    localparam logic [7:0] I_DD   = 8'h02;
    localparam logic [7:0] I_ACK  = 8'h01;

    // Expected flag bits: {DispReq, ChgReq, CoinRej, Busy}
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_REJ  = 4'b0010;
    localparam logic [3:0] F_VEND = 4'b1001;
    localparam logic [3:0] F_CHG  = 4'b0101;

    typedef struct {
        string        tag;
        logic [CW-1:0] credit;
        logic [3:0]   flags;
    } exp_t;

    logic          Clk;
    logic          Reset;
    logic          N;
    logic          D;
    logic          Q;
    logic          Sel;
    logic          Cancel;
    logic          DispDone;
    logic          ChgAck;
    logic          DispReq;
    logic          ChgReq;
    logic          CoinRej;
    logic          Busy;
    logic [CW-1:0] Credit;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    vend_sequencer #(
        .PRICE      (15),
        .MAX_CREDIT (100),
        .CREDIT_W   (CW),
        .TIMEOUT    (TO)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .N        (N),
        .D        (D),
        .Q        (Q),
        .Sel      (Sel),
        .Cancel   (Cancel),
        .DispDone (DispDone),
        .ChgAck   (ChgAck),
        .DispReq  (DispReq),
        .ChgReq   (ChgReq),
        .CoinRej  (CoinRej),
        .Busy     (Busy),
        .Credit   (Credit)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One clock of stimulus followed by comparison of the queued expectation
    task automatic step(input string tag, input logic [7:0] in,
                        input logic [CW-1:0] exp_credit, input logic [3:0] exp_flags);
        exp_t e;
        logic [3:0] obs;
        {Reset, N, D, Q, Sel, Cancel, DispDone, ChgAck} = in;
        sb.push_back('{tag, exp_credit, exp_flags});
        @(posedge Clk);
        #1;
        e   = sb.pop_front();
        obs = {DispReq, ChgReq, CoinRej, Busy};
        checks++;
        assert (Credit === e.credit) else begin
            errors++;
            $error("FAIL %s credit observed=%0d expected=%0d", e.tag, Credit, e.credit);
        end
        checks++;
        assert (obs === e.flags) else begin
            errors++;
            $error("FAIL %s flags{disp,chg,rej,busy} observed=%b expected=%b", e.tag, obs, e.flags);
        end
    endtask

    // Safety net in case the stimulus sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        {Reset, N, D, Q, Sel, Cancel, DispDone, ChgAck} = '0;

        step("reset", I_RST, 0, F_NONE);
        step("idle0", I_NONE, 0, F_NONE);

        // Exact payment, no change owed
        step("s1_n",    I_N,    5,  F_NONE);
        step("s1_d",    I_D,    15, F_NONE);
        step("s1_sel",  I_SEL,  0,  F_VEND);
        step("s1_hold", I_NONE, 0,  F_VEND);
        step("s1_done", I_DD,   0,  F_NONE);
        step("s1_idle", I_NONE, 0,  F_NONE);

        // Overpay, dispense held three cycles, two nickels back
        step("s2_q",     I_Q,    25, F_NONE);
        step("s2_sel",   I_SEL,  10, F_VEND);
        step("s2_hold1", I_NONE, 10, F_VEND);
        step("s2_hold2", I_NONE, 10, F_VEND);
        step("s2_done",  I_DD,   10, F_CHG);
        step("s2_ack1",  I_ACK,  5,  F_CHG);
        step("s2_ack2",  I_ACK,  0,  F_NONE);
        step("s2_ackid", I_ACK,  0,  F_NONE);

        // Cancel beats Sel; same-cycle coin and coin during change are returned
        step("s3_d",     I_D,                 10, F_NONE);
        step("s3_can",   I_CAN | I_SEL | I_N, 10, F_CHG | F_REJ);
        step("s3_dchg",  I_D,                 10, F_CHG | F_REJ);
        step("s3_wait",  I_NONE,              10, F_CHG);
        step("s3_ack1",  I_ACK,               5,  F_CHG);
        step("s3_ack2",  I_ACK,               0,  F_NONE);
        step("s3_ddidl", I_DD,                0,  F_NONE);

        // Credit ceiling
        step("s4_q1",   I_Q,    25,  F_NONE);
        step("s4_q2",   I_Q,    50,  F_NONE);
        step("s4_q3",   I_Q,    75,  F_NONE);
        step("s4_q4",   I_Q,    100, F_NONE);
        step("s4_q5",   I_Q,    100, F_REJ);
        step("s4_n",    I_N,    100, F_REJ);
        step("s4_quiet", I_NONE, 100, F_NONE);

        // Simultaneous coins after reset, then back-to-back change
        step("s4_rst",   I_RST,             0,  F_NONE);
        step("s4_ndq",   I_N | I_D | I_Q,   25, F_REJ);
        step("s4_after", I_NONE,            25, F_NONE);
        step("s4_can",   I_CAN,             25, F_CHG);
        step("s4_ack1",  I_ACK,             20, F_CHG);
        step("s4_ack2",  I_ACK,             15, F_CHG);
        step("s4_ack3",  I_ACK,             10, F_CHG);
        step("s4_ack4",  I_ACK,             5,  F_CHG);
        step("s4_ack5",  I_ACK,             0,  F_NONE);

        // Coin accepted right after return to idle; short Sel ignored; timeout refund
        step("s5_n",   I_N,   5, F_NONE);
        step("s5_sel", I_SEL, 5, F_NONE);
        for (int i = 0; i < int'(TO) - 2; i++) begin
            step("s5_idle", I_NONE, 5, F_NONE);
        end
        step("s5_tmo",  I_NONE, 5, F_CHG);
        step("s5_ack",  I_ACK,  0, F_NONE);
        step("s5_idle2", I_NONE, 0, F_NONE);

        // Reset during dispense abandons the transaction
        step("s6_d",    I_D,    10, F_NONE);
        step("s6_n",    I_N,    15, F_NONE);
        step("s6_sel",  I_SEL,  0,  F_VEND);
        step("s6_rst",  I_RST,  0,  F_NONE);
        step("s6_dd",   I_DD,   0,  F_NONE);
        step("s6_idle", I_NONE, 0,  F_NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
